// File: rtl/aes_decipher_ctrl_pkg.sv
// Shared AES decipher control constants: op codes, round counts, key length codes.
package aes_decipher_ctrl_pkg;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_INIT  = 3'd1;
  localparam logic [2:0] OP_SBOX  = 3'd2;
  localparam logic [2:0] OP_MAIN  = 3'd3;
  localparam logic [2:0] OP_FINAL = 3'd4;

  localparam logic [3:0] AES128_ROUNDS = 4'ha;
  localparam logic [3:0] AES256_ROUNDS = 4'he;

  localparam logic AES_128_BIT_KEY = 1'b0;
  localparam logic AES_256_BIT_KEY = 1'b1;

  function automatic logic [3:0] num_rounds(input logic keylen);
    return (keylen == AES_256_BIT_KEY) ? AES256_ROUNDS : AES128_ROUNDS;
  endfunction

endpackage

// File: rtl/aes_decipher_ctrl_if.sv
// Control bus between aes_core (master) and the decipher sequencer (slave).
interface aes_decipher_ctrl_if;
  logic       next;
  logic       keylen;
  logic       ready;
  logic [2:0] op;
  logic [3:0] round_key_addr;
  logic [1:0] sword_idx;
  logic [3:0] block_we;

  modport master (
    output next, keylen,
    input  ready, op, round_key_addr, sword_idx, block_we
  );

  modport slave (
    input  next, keylen,
    output ready, op, round_key_addr, sword_idx, block_we
  );
endinterface

// File: rtl/aes_decipher_ctrl.sv
// Moore sequencer for one AES block decryption: INIT, then NR x (4 SBOX words + 1 round op).
module aes_decipher_ctrl
  import aes_decipher_ctrl_pkg::*;
(
  input logic                clk,
  input logic                reset_n,
  aes_decipher_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_SBOX, S_ROUND} state_t;

  state_t     state, state_nxt;
  logic [3:0] round_ctr, round_ctr_nxt;
  logic [1:0] sword_ctr, sword_ctr_nxt;
  logic       keylen_reg, keylen_nxt;
  logic       ready_reg, ready_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      round_ctr  <= '0;
      sword_ctr  <= '0;
      keylen_reg <= 1'b0;
      ready_reg  <= 1'b1;
    end else begin
      state      <= state_nxt;
      round_ctr  <= round_ctr_nxt;
      sword_ctr  <= sword_ctr_nxt;
      keylen_reg <= keylen_nxt;
      ready_reg  <= ready_nxt;
    end
  end

  // Outputs depend only on registered state; next/keylen only steer next-state.
  always_comb begin
    state_nxt          = state;
    round_ctr_nxt      = round_ctr;
    sword_ctr_nxt      = sword_ctr;
    keylen_nxt         = keylen_reg;
    ready_nxt          = ready_reg;
    bus.op             = OP_NONE;
    bus.block_we       = 4'h0;
    bus.sword_idx      = 2'd0;
    bus.round_key_addr = round_ctr;
    bus.ready          = ready_reg;

    case (state)
      S_IDLE: begin
        if (bus.next) begin
          state_nxt     = S_INIT;
          round_ctr_nxt = num_rounds(bus.keylen);
          keylen_nxt    = bus.keylen;
          ready_nxt     = 1'b0;
        end
      end
      S_INIT: begin
        bus.op        = OP_INIT;
        bus.block_we  = 4'hf;
        state_nxt     = S_SBOX;
        round_ctr_nxt = num_rounds(keylen_reg) - 4'd1;
        sword_ctr_nxt = 2'd0;
      end
      S_SBOX: begin
        bus.op        = OP_SBOX;
        bus.sword_idx = sword_ctr;
        bus.block_we  = 4'b0001 << sword_ctr;
        sword_ctr_nxt = sword_ctr + 2'd1;
        if (sword_ctr == 2'd3) state_nxt = S_ROUND;
      end
      S_ROUND: begin
        bus.block_we = 4'hf;
        if (round_ctr != 4'd0) begin
          bus.op        = OP_MAIN;
          state_nxt     = S_SBOX;
          round_ctr_nxt = round_ctr - 4'd1;
        end else begin
          bus.op    = OP_FINAL;
          state_nxt = S_IDLE;
          ready_nxt = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
